dual_bank_arbiter: RTL and testbench
====================================

DUAL_BANK_ARBITER -- requirements
Module: dual_bank_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 8, data bits per word.
- ADDR_WIDTH, 6, word address bits.
- NUM_BANKS, 4, single-port banks; power of 2, at least 2.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- a_req, input, 1, port A access request; held until granted.
- a_wr, input, 1, port A write (1) or read (0).
- a_addr, input, ADDR_WIDTH, port A word address.
- a_wdata, input, DATA_WIDTH, port A write data.
- a_gnt, output, 1, port A access accepted this cycle.
- a_rdata, output, DATA_WIDTH, port A read data.
- a_rvalid, output, 1, a_rdata valid pulse.
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: port B equivalents, same widths and meanings.
- conflict_cnt, output, 16, saturating count of bank-conflict cycles.
REQ-003 The design SHALL have one clock (clk) and an asynchronous active-low reset (rst_n).

Function
REQ-004 Bank SHALL be addr[log2(NUM_BANKS)-1:0]; row SHALL be the remaining upper address bits; storage is internal, NUM_BANKS x 2^ADDR_WIDTH/NUM_BANKS words.
REQ-005 Conflict SHALL be a_req and b_req both high with equal bank fields, regardless of read/write or row.
REQ-006 With no conflict, each requesting port SHALL receive gnt combinationally in the same cycle; different-bank A and B accesses complete in parallel.
REQ-007 On conflict exactly one gnt SHALL assert per the arbitration policy (REQ-014); the loser SHALL see gnt low and must hold req/addr/wr/wdata.
REQ-008 A granted write SHALL update the addressed word at the clock edge where req and gnt are both high.
REQ-009 A granted read SHALL drive rdata and pulse rvalid for exactly one cycle, the cycle after grant (latency 1).
REQ-010 rdata SHALL hold its last value while rvalid is low.
REQ-011 Back-to-back granted reads on one port SHALL yield rvalid high on consecutive cycles with no bubble.
REQ-012 conflict_cnt SHALL increment by 1 each conflict cycle and saturate at 16'hFFFF, with no wrap.
REQ-013 A gnt SHALL never assert while its req is low.

Reset
REQ-014 Arbitration policy:
- With DUAL_ARB_RR_EN: the last-winner register decides.
- Without it: port A always wins.
REQ-015 rst_n low SHALL immediately clear, asynchronously:
- a_rvalid, b_rvalid, a_rdata, b_rdata to 0;
- conflict_cnt to 0;
- last-winner register to "B" (so A wins the first conflict).
REQ-016 gnt outputs SHALL be 0 while rst_n is low.
REQ-017 A read granted in the cycle reset asserts SHALL produce no rvalid.
REQ-018 Memory contents SHALL NOT be reset; reads of unwritten words are undefined.
REQ-019 Held requests SHALL be re-arbitrated normally from the first edge after rst_n deasserts.

Configuration
REQ-020 Macro DUAL_ARB_RR_EN SHALL select the arbitration policy.
REQ-021 Defined: round-robin. The last-winner register updates only on conflict cycles, and the next conflict goes to the other port, so neither port waits more than one conflict cycle.
REQ-022 Undefined: fixed priority, port A wins every conflict, and the last-winner register is not implemented.
REQ-023 Both builds SHALL keep identical ports and non-conflict behaviour.

Verification
REQ-024 Parallel access: A writes 0x5A to addr 0x04 (bank 0), B writes 0xC3 to 0x05 (bank 1) in the same cycle -> both gnt=1; subsequent reads return 0x5A and 0xC3, rvalid one cycle after each grant; conflict_cnt=0.
REQ-025 Bank conflict: A reads 0x04, B reads 0x08 (both bank 0) in the same cycle -> a_gnt=1, b_gnt=0, conflict_cnt=1; next cycle b_gnt=1, a_rvalid=1.
REQ-026 Round-robin (DUAL_ARB_RR_EN): three consecutive conflict cycles with both ports re-requesting -> winners A, B, A; fixed build -> A, A, A with b_gnt=0 throughout.
REQ-027 Saturation: force 65540 conflict cycles -> conflict_cnt stops at 0xFFFF.
REQ-028 Reset mid-read: assert rst_n low in the cycle a_gnt=1 for a read -> a_rvalid stays 0; after release, held a_req is granted again and conflict_cnt=0.
REQ-029 Same-bank write/read: A writes 0x11 to 0x00 while B reads 0x00 -> A granted first; B's later read returns 0x11.

Source files
------------

// File: rtl/dual_bank_arbiter.sv
// dual_bank_arbiter: two request ports sharing NUM_BANKS single-port banks.
// Bank = low address bits, row = remaining upper bits. Same-bank requests in
// one cycle are a conflict: one port is granted, the other holds its request.
// Build option: define DUAL_ARB_RR_EN for round-robin conflict arbitration;
// without it port A wins every conflict and no last-winner state exists.
module dual_bank_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BANKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic [15:0]           conflict_cnt
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROWS      = 1 << ROW_BITS;

    logic [BANK_BITS-1:0]  a_bank_s, b_bank_s;
    logic [ROW_BITS-1:0]   a_row_s, b_row_s;
    logic                  conflict_s;
    logic                  a_wins_s;
    logic                  a_gnt_s, b_gnt_s;

    logic                  a_rvalid_d, a_rvalid_q;
    logic                  b_rvalid_d, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_d, a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_d, b_rdata_q;
    logic [15:0]           conflict_cnt_d, conflict_cnt_q;

    // Storage is deliberately not reset; contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];

    assign a_bank_s = a_addr[BANK_BITS-1:0];
    assign b_bank_s = b_addr[BANK_BITS-1:0];
    assign a_row_s  = a_addr[ADDR_WIDTH-1:BANK_BITS];
    assign b_row_s  = b_addr[ADDR_WIDTH-1:BANK_BITS];

`ifdef DUAL_ARB_RR_EN
    // 1 = port B won the most recent conflict, so A takes the next one.
    logic last_win_b_d, last_win_b_q;

    // Last-winner update: flips only on conflict cycles.
    always_comb begin
        last_win_b_d = last_win_b_q;
        if (conflict_s) begin
            last_win_b_d = ~a_wins_s;
        end else begin
            last_win_b_d = last_win_b_q;
        end
    end

    // Last-winner register; reset to B so A wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_b_q <= 1'b1;
        end else begin
            last_win_b_q <= last_win_b_d;
        end
    end

    assign a_wins_s = last_win_b_q;
`else
    assign a_wins_s = 1'b1;
`endif

    // Grant decode: combinational same-cycle grant, gated off during reset.
    always_comb begin
        conflict_s = a_req & b_req & (a_bank_s == b_bank_s);
        a_gnt_s    = rst_n & a_req & (~conflict_s | a_wins_s);
        b_gnt_s    = rst_n & b_req & (~conflict_s | ~a_wins_s);
    end

    // Next-state for read-return registers and the conflict counter.
    always_comb begin
        a_rvalid_d     = a_gnt_s & ~a_wr;
        b_rvalid_d     = b_gnt_s & ~b_wr;
        a_rdata_d      = a_rdata_q;
        b_rdata_d      = b_rdata_q;
        conflict_cnt_d = conflict_cnt_q;
        if (a_rvalid_d) begin
            a_rdata_d = mem_q[a_bank_s][a_row_s];
        end else begin
            a_rdata_d = a_rdata_q;
        end
        if (b_rvalid_d) begin
            b_rdata_d = mem_q[b_bank_s][b_row_s];
        end else begin
            b_rdata_d = b_rdata_q;
        end
        if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Read-return and counter registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            conflict_cnt_q <= 16'd0;
        end else begin
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Bank writes; arbitration guarantees at most one writer per bank.
    always_ff @(posedge clk) begin
        if (a_gnt_s && a_wr) begin
            mem_q[a_bank_s][a_row_s] <= a_wdata;
        end
        if (b_gnt_s && b_wr) begin
            mem_q[b_bank_s][b_row_s] <= b_wdata;
        end
    end

    assign a_gnt        = a_gnt_s;
    assign b_gnt        = b_gnt_s;
    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dual_bank_arbiter.sv
// Self-checking bench for dual_bank_arbiter: directed scenarios plus random
// traffic compared each cycle against a flat-memory reference model.
`timescale 1ns/1ps
module tb_dual_bank_arbiter;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int NB = 4;
`ifdef DUAL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [15:0]   conflict_cnt;

    dual_bank_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .conflict_cnt(conflict_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: flat word memory plus port-level expectations.
    logic [DW-1:0] m_mem [64];
    bit            m_a_first;
    int            m_cnt;
    bit            m_a_rv, m_b_rv;
    logic [DW-1:0] m_a_rd, m_b_rd;
    bit            e_a, e_b;

    // Values observed at the most recent checking edge.
    logic          o_a_gnt, o_b_gnt, o_a_rv, o_b_rv;
    logic [DW-1:0] o_a_rd, o_b_rd;
    logic [15:0]   o_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_a_first = 1'b1;
        m_cnt     = 0;
        m_a_rv    = 1'b0;
        m_b_rv    = 1'b0;
        m_a_rd    = '0;
        m_b_rd    = '0;
        e_a       = 1'b0;
        e_b       = 1'b0;
    endtask

    task automatic drive(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    endtask

    // One clock cycle: check outputs at the falling edge, advance model at the rising edge.
    task automatic step();
        bit conf, aw;
        @(negedge clk);
        conf = a_req && b_req && ((int'(a_addr) % NB) == (int'(b_addr) % NB));
        aw   = RR ? m_a_first : 1'b1;
        e_a  = a_req && (!conf || aw);
        e_b  = b_req && (!conf || !aw);
        o_a_gnt = a_gnt; o_b_gnt = b_gnt; o_a_rv = a_rvalid; o_b_rv = b_rvalid;
        o_a_rd = a_rdata; o_b_rd = b_rdata; o_cnt = conflict_cnt;
        check_val("a_gnt", 32'(o_a_gnt), 32'(e_a));
        check_val("b_gnt", 32'(o_b_gnt), 32'(e_b));
        check_val("a_rvalid", 32'(o_a_rv), 32'(m_a_rv));
        check_val("b_rvalid", 32'(o_b_rv), 32'(m_b_rv));
        check_val("a_rdata", 32'(o_a_rd), 32'(m_a_rd));
        check_val("b_rdata", 32'(o_b_rd), 32'(m_b_rd));
        check_val("conflict_cnt", 32'(o_cnt), 32'(m_cnt));
        @(posedge clk);
        m_a_rv = e_a && !a_wr;
        m_b_rv = e_b && !b_wr;
        if (m_a_rv) m_a_rd = m_mem[a_addr];
        if (m_b_rv) m_b_rd = m_mem[b_addr];
        if (e_a && a_wr) m_mem[a_addr] = a_wdata;
        if (e_b && b_wr) m_mem[b_addr] = b_wdata;
        if (conf) begin
            if (m_cnt < 65535) m_cnt++;
            m_a_first = !aw;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        check_val("rst_cnt", 32'(conflict_cnt), 32'd0);
        check_val("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random traffic; a port that was refused keeps its request unchanged.
    task automatic rand_drive();
        if (!(a_req && !e_a)) begin
            a_req   = ($urandom_range(0, 3) != 0);
            a_wr    = 1'($urandom_range(0, 1));
            a_addr  = 6'($urandom_range(0, 63));
            a_wdata = 8'($urandom);
        end
        if (!(b_req && !e_b)) begin
            b_req   = ($urandom_range(0, 3) != 0);
            b_wr    = 1'($urandom_range(0, 1));
            b_addr  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) b_addr[1:0] = a_addr[1:0];
            b_wdata = 8'($urandom);
        end
    endtask

    logic [2:0] pat;

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1, 0, 6'h04, 8'h00, 1, 0, 6'h05, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check_val("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        check_val("rst_cnt0", 32'(conflict_cnt), 32'd0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        rst_n = 1'b1;

        // Fill every word through port A so later reads are defined.
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, 6'(i), 8'(i * 7 + 3), 0, 0, '0, '0);
            step();
        end

        // Parallel writes to different banks, then parallel reads.
        drive(1, 1, 6'h04, 8'h5A, 1, 1, 6'h05, 8'hC3);
        step();
        check_val("par_wr_gnt", 32'({o_a_gnt, o_b_gnt}), 32'd3);
        drive(1, 0, 6'h04, 8'h00, 1, 0, 6'h05, 8'h00);
        step();
        check_val("par_rd_gnt", 32'({o_a_gnt, o_b_gnt}), 32'd3);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_val("par_rvalid", 32'({o_a_rv, o_b_rv}), 32'd3);
        check_val("par_a_rdata", 32'(o_a_rd), 32'h5A);
        check_val("par_b_rdata", 32'(o_b_rd), 32'hC3);
        check_val("par_cnt", 32'(o_cnt), 32'd0);

        // Same-bank reads: A first, B the following cycle.
        drive(1, 0, 6'h04, 8'h00, 1, 0, 6'h08, 8'h00);
        step();
        check_val("cf_gnt", 32'({o_a_gnt, o_b_gnt}), 32'd2);
        a_req = 1'b0;
        step();
        check_val("cf_b_gnt", 32'(o_b_gnt), 32'd1);
        check_val("cf_a_rvalid", 32'(o_a_rv), 32'd1);
        check_val("cf_a_rdata", 32'(o_a_rd), 32'h5A);
        check_val("cf_cnt", 32'(o_cnt), 32'd1);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_val("cf_b_rdata", 32'(o_b_rd), 32'h3B);

        // Three back-to-back conflict cycles with both ports re-requesting.
        do_reset();
        pat = RR ? 3'b101 : 3'b111;
        drive(1, 0, 6'h01, 8'h00, 1, 0, 6'h05, 8'h00);
        for (int i = 2; i >= 0; i--) begin
            step();
            check_val("arb_a_gnt", 32'(o_a_gnt), 32'(pat[i]));
            check_val("arb_b_gnt", 32'(o_b_gnt), 32'(!pat[i]));
        end

        // Counter saturation.
        do_reset();
        drive(1, 0, 6'h02, 8'h00, 1, 0, 6'h06, 8'h00);
        repeat (65540) step();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_val("sat_cnt", 32'(o_cnt), 32'hFFFF);

        // Random mixed traffic.
        for (int i = 0; i < 2000; i++) begin
            rand_drive();
            step();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();

        // Reset asserted in the cycle a read is granted.
        drive(1, 0, 6'h10, 8'h00, 0, 0, '0, '0);
        @(negedge clk);
        check_val("mr_gnt_pre", 32'(a_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("mr_gnt_rst", 32'(a_gnt), 32'd0);
        check_val("mr_rvalid0", 32'(a_rvalid), 32'd0);
        @(posedge clk);
        #1;
        check_val("mr_rvalid1", 32'(a_rvalid), 32'd0);
        check_val("mr_cnt", 32'(conflict_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        check_val("mr_regrant", 32'(o_a_gnt), 32'd1);
        check_val("mr_cnt_after", 32'(o_cnt), 32'd0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_val("mr_rvalid2", 32'(o_a_rv), 32'd1);

        // Same-bank write by A while B reads the same word.
        drive(1, 1, 6'h00, 8'h11, 1, 0, 6'h00, 8'h00);
        step();
        check_val("wr_rd_gnt", 32'({o_a_gnt, o_b_gnt}), 32'd2);
        a_req = 1'b0;
        step();
        check_val("wr_rd_b_gnt", 32'(o_b_gnt), 32'd1);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        step();
        check_val("wr_rd_rvalid", 32'(o_b_rv), 32'd1);
        check_val("wr_rd_rdata", 32'(o_b_rd), 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
